executor_clear: RTL and testbench

- Line-clear stage directly downstream of the commit stage; started once the commit stage pulses done, after the landed shape has been merged into matrix memory.
- Scans matrix memory bottom-up, one row at a time, and drops every full row.
- Compacts the surviving rows downward, zero-fills the vacated top rows, then reports the number of rows cleared to the score/controller logic.

---
 rtl/executor_clear_if.sv | 27 ++
 rtl/executor_clear.sv | 150 +++++++++++++++
 tb/tb_executor_clear.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/executor_clear_if.sv
// Row-memory port between the line-clear executor (master) and the matrix memory (slave).
interface executor_clear_if #(
    parameter int width_p  = 16,
    parameter int height_p = 32
);
    localparam int aw_lp = $clog2(height_p);

    // Handshake: mm_wr_v is a one-cycle request. The master then holds off all
    // further writes until mm_is_ready is seen high. Read data is valid one
    // cycle after mm_rd_addr is presented.
    logic [aw_lp-1:0]   mm_rd_addr;
    logic [width_p-1:0] mm_rd_data;
    logic [aw_lp-1:0]   mm_wr_addr;
    logic [width_p-1:0] mm_wr_data;
    logic               mm_wr_v;
    logic               mm_is_ready;

    modport master (
        output mm_rd_addr, mm_wr_addr, mm_wr_data, mm_wr_v,
        input  mm_rd_data, mm_is_ready
    );

    modport slave (
        input  mm_rd_addr, mm_wr_addr, mm_wr_data, mm_wr_v,
        output mm_rd_data, mm_is_ready
    );
endinterface

// File: rtl/executor_clear.sv
// Line-clear stage: scans rows bottom-up, drops full rows, compacts and zero-fills the top.
// Optional EXECUTOR_CLEAR_EARLY_EXIT_EN stops the scan at the first all-zero row.
module executor_clear #(
    parameter int width_p  = 16,
    parameter int height_p = 32,
    parameter int debug_p  = 0
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          v_i,
    output logic                          done_o,
    output logic                          busy_o,
    output logic [$clog2(height_p+1)-1:0] lines_cleared_o,
    output logic [2:0]                    state_o,
    output logic [$clog2(height_p)-1:0]   dbg_rd_o,
    output logic [$clog2(height_p)-1:0]   dbg_wr_o,
    output logic [width_p-1:0]            dbg_row_o,
    executor_clear_if.master              mm
);
    localparam int aw_lp = $clog2(height_p);
    localparam int cw_lp = $clog2(height_p + 1);
    localparam logic [aw_lp-1:0] bottom_lp = aw_lp'(height_p - 1);
    localparam logic [cw_lp-1:0] cnt_max_lp = cw_lp'(height_p);

    typedef enum logic [2:0] {
        eIDLE  = 3'd0,
        eRead  = 3'd1,
        eCheck = 3'd2,
        eWrite = 3'd3,
        eWaitW = 3'd4,
        eFill  = 3'd5,
        eFillW = 3'd6,
        eDone  = 3'd7
    } state_e;

    state_e             state_r, state_n;
    logic [aw_lp-1:0]   rd_r, rd_n;
    logic [aw_lp-1:0]   wr_r, wr_n;
    logic [cw_lp-1:0]   cnt_r, cnt_n;
    logic [cw_lp-1:0]   lines_r, lines_n;
    logic [width_p-1:0] row_r, row_n;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= eIDLE;
            rd_r    <= bottom_lp;
            wr_r    <= bottom_lp;
            cnt_r   <= '0;
            lines_r <= '0;
            row_r   <= '0;
        end else begin
            state_r <= state_n;
            rd_r    <= rd_n;
            wr_r    <= wr_n;
            cnt_r   <= cnt_n;
            lines_r <= lines_n;
            row_r   <= row_n;
        end
    end

    always_comb begin
        state_n = state_r;
        rd_n    = rd_r;
        wr_n    = wr_r;
        cnt_n   = cnt_r;
        lines_n = lines_r;
        row_n   = row_r;
        case (state_r)
            eIDLE: begin
                if (v_i) begin
                    state_n = eRead;
                    rd_n    = bottom_lp;
                    wr_n    = bottom_lp;
                    cnt_n   = '0;
                end
            end
            eRead: state_n = eCheck;
            eCheck: begin
                row_n = mm.mm_rd_data;
                if (&mm.mm_rd_data) begin
                    if (cnt_r != cnt_max_lp) cnt_n = cnt_r + cw_lp'(1);
                    if (rd_r == '0) begin
                        state_n = eFill;
                    end else begin
                        rd_n    = rd_r - aw_lp'(1);
                        state_n = eRead;
                    end
`ifdef EXECUTOR_CLEAR_EARLY_EXIT_EN
                // An empty row means everything above is empty: only wr_r..rd_r needs clearing.
                end else if (mm.mm_rd_data == '0) begin
                    state_n = (wr_r == rd_r) ? eDone : eFill;
`endif
                end else if (wr_r != rd_r) begin
                    state_n = eWrite;
                end else if (rd_r == '0) begin
                    state_n = eDone;
                end else begin
                    rd_n    = rd_r - aw_lp'(1);
                    wr_n    = wr_r - aw_lp'(1);
                    state_n = eRead;
                end
            end
            eWrite: state_n = eWaitW;
            eWaitW: begin
                if (mm.mm_is_ready) begin
                    wr_n = wr_r - aw_lp'(1);
                    if (rd_r == '0) begin
                        state_n = eFill;
                    end else begin
                        rd_n    = rd_r - aw_lp'(1);
                        state_n = eRead;
                    end
                end
            end
            eFill: state_n = eFillW;
            eFillW: begin
                // rd_r marks the last row to clear: row 0 normally, the empty row on early exit.
                if (mm.mm_is_ready) begin
                    if (wr_r == rd_r) begin
                        state_n = eDone;
                    end else begin
                        wr_n    = wr_r - aw_lp'(1);
                        state_n = eFill;
                    end
                end
            end
            eDone: begin
                lines_n = cnt_r;
                state_n = eIDLE;
            end
            default: state_n = eIDLE;
        endcase
    end

    always_comb begin
        done_o          = (state_r == eDone);
        busy_o          = (state_r != eIDLE);
        lines_cleared_o = lines_r;
        state_o         = state_r;
        mm.mm_rd_addr   = rd_r;
        mm.mm_wr_addr   = wr_r;
        mm.mm_wr_v      = (state_r == eWrite) || (state_r == eFill);
        mm.mm_wr_data   = (state_r == eWrite) ? row_r : '0;
    end

    // Pointer/row trace is only driven when debug_p is set.
    assign dbg_rd_o  = (debug_p != 0) ? rd_r  : '0;
    assign dbg_wr_o  = (debug_p != 0) ? wr_r  : '0;
    assign dbg_row_o = (debug_p != 0) ? row_r : '0;
endmodule

// File: tb/tb_executor_clear.sv
// Directed bench for executor_clear with a row-memory model and stallable write-ready.
module tb_executor_clear;
    logic        clk;
    logic        reset_i;
    logic        v_i;
    logic        done_o;
    logic        busy_o;
    logic [5:0]  lines_cleared_o;
    logic [2:0]  state_o;
    logic [4:0]  dbg_rd_o;
    logic [4:0]  dbg_wr_o;
    logic [15:0] dbg_row_o;

    executor_clear_if #(.width_p(16), .height_p(32)) mm_if ();

    executor_clear #(.width_p(16), .height_p(32), .debug_p(1)) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .v_i             (v_i),
        .done_o          (done_o),
        .busy_o          (busy_o),
        .lines_cleared_o (lines_cleared_o),
        .state_o         (state_o),
        .dbg_rd_o        (dbg_rd_o),
        .dbg_wr_o        (dbg_wr_o),
        .dbg_row_o       (dbg_row_o),
        .mm              (mm_if)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // memory model
    logic [15:0] mem      [32];
    logic [15:0] init_mem [32];
    logic        do_load  = 1'b0;
    int          stall_len = 0;
    int          stall_cnt = 0;
    int          wr_count  = 0;
    int          viol      = 0;
    logic        prev_wr_v = 1'b0;

    assign mm_if.mm_is_ready = (stall_cnt == 0);

    always @(posedge clk) begin
        mm_if.mm_rd_data <= mem[mm_if.mm_rd_addr];
        if (do_load) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_mem[i];
        end else if (mm_if.mm_wr_v) begin
            mem[mm_if.mm_wr_addr] <= mm_if.mm_wr_data;
            wr_count++;
        end
        if (mm_if.mm_wr_v && (prev_wr_v || stall_cnt != 0)) viol++;
        prev_wr_v <= mm_if.mm_wr_v;
        if (mm_if.mm_wr_v) stall_cnt <= stall_len;
        else if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
    end

    // driver tasks
    task automatic load_board(input logic [15:0] r31, input logic [15:0] r30,
                              input logic [15:0] r29, input logic [15:0] r28, input bit all_full);
        for (int i = 0; i < 32; i++) init_mem[i] = all_full ? 16'hFFFF : 16'h0000;
        if (!all_full) begin
            init_mem[31] = r31; init_mem[30] = r30; init_mem[29] = r29; init_mem[28] = r28;
        end
        @(negedge clk) do_load = 1'b1;
        @(negedge clk) do_load = 1'b0;
    endtask

    task automatic run_clear(output int cycles, output bit seen);
        @(negedge clk) v_i = 1'b1;
        @(negedge clk) v_i = 1'b0;
        cycles = 1;
        seen   = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
            cycles++;
        end
    endtask

    // scenario tasks
    task automatic test_reset;
        reset_i = 1'b1;
        v_i     = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done_o); end
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        n_cmp++; if (mm_if.mm_wr_v !== 1'b0) begin n_fail++; $display("FAIL reset_wr_v got=%b exp=0", mm_if.mm_wr_v); end
        n_cmp++; if (lines_cleared_o !== 6'd0) begin n_fail++; $display("FAIL reset_lines got=%0d exp=0", lines_cleared_o); end
        n_cmp++; if (mm_if.mm_rd_addr !== 5'd31) begin n_fail++; $display("FAIL reset_rd_addr got=%0d exp=31", mm_if.mm_rd_addr); end
        @(negedge clk) reset_i = 1'b0;
    endtask

    task automatic test_empty;
        int cycles; bit seen; int w0; int exp_cycles;
`ifdef EXECUTOR_CLEAR_EARLY_EXIT_EN
        exp_cycles = 3;
`else
        exp_cycles = 65;
`endif
        load_board(16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
        w0 = wr_count;
        run_clear(cycles, seen);
        n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL empty_timeout got=%b exp=1", seen); end
        n_cmp++; if (cycles != exp_cycles) begin n_fail++; $display("FAIL empty_cycles got=%0d exp=%0d", cycles, exp_cycles); end
        @(negedge clk);
        n_cmp++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL empty_pulse got=%b%b exp=00", done_o, busy_o); end
        n_cmp++; if (wr_count - w0 != 0) begin n_fail++; $display("FAIL empty_writes got=%0d exp=0", wr_count - w0); end
        n_cmp++; if (lines_cleared_o !== 6'd0) begin n_fail++; $display("FAIL empty_lines got=%0d exp=0", lines_cleared_o); end
    endtask

    task automatic test_one_move;
        int cycles; bit seen; int w0; int exp_w;
`ifdef EXECUTOR_CLEAR_EARLY_EXIT_EN
        exp_w = 3;
`else
        exp_w = 32;
`endif
        load_board(16'hFFFF, 16'h0001, 16'h0, 16'h0, 1'b0);
        w0 = wr_count;
        run_clear(cycles, seen);
        @(negedge clk);
        n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL one_timeout got=%b exp=1", seen); end
        n_cmp++; if (lines_cleared_o !== 6'd1) begin n_fail++; $display("FAIL one_lines got=%0d exp=1", lines_cleared_o); end
        n_cmp++; if (wr_count - w0 != exp_w) begin n_fail++; $display("FAIL one_writes got=%0d exp=%0d", wr_count - w0, exp_w); end
        for (int i = 0; i < 32; i++) begin
            logic [15:0] e;
            e = (i == 31) ? 16'h0001 : 16'h0000;
            n_cmp++; if (mem[i] !== e) begin n_fail++; $display("FAIL one_row%0d got=%h exp=%h", i, mem[i], e); end
        end
    endtask

    task automatic test_two_full(input int stall, input string tag);
        int cycles; bit seen; int w0; int v0; int exp_w;
`ifdef EXECUTOR_CLEAR_EARLY_EXIT_EN
        exp_w = 5;
`else
        exp_w = 32;
`endif
        stall_len = stall;
        load_board(16'hFFFF, 16'h00F0, 16'hFFFF, 16'h8001, 1'b0);
        w0 = wr_count;
        v0 = viol;
        run_clear(cycles, seen);
        @(negedge clk);
        stall_len = 0;
        n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL %s_timeout got=%b exp=1", tag, seen); end
        n_cmp++; if (lines_cleared_o !== 6'd2) begin n_fail++; $display("FAIL %s_lines got=%0d exp=2", tag, lines_cleared_o); end
        n_cmp++; if (wr_count - w0 != exp_w) begin n_fail++; $display("FAIL %s_writes got=%0d exp=%0d", tag, wr_count - w0, exp_w); end
        n_cmp++; if (viol - v0 != 0) begin n_fail++; $display("FAIL %s_wr_pulse got=%0d exp=0", tag, viol - v0); end
        for (int i = 0; i < 32; i++) begin
            logic [15:0] e;
            e = (i == 31) ? 16'h00F0 : (i == 30) ? 16'h8001 : 16'h0000;
            n_cmp++; if (mem[i] !== e) begin n_fail++; $display("FAIL %s_row%0d got=%h exp=%h", tag, i, mem[i], e); end
        end
    endtask

    task automatic test_all_full;
        int cycles; bit seen; int w0;
        load_board(16'h0, 16'h0, 16'h0, 16'h0, 1'b1);
        w0 = wr_count;
        run_clear(cycles, seen);
        @(negedge clk);
        n_cmp++; if (seen !== 1'b1) begin n_fail++; $display("FAIL full_timeout got=%b exp=1", seen); end
        n_cmp++; if (lines_cleared_o !== 6'd32) begin n_fail++; $display("FAIL full_lines got=%0d exp=32", lines_cleared_o); end
        n_cmp++; if (wr_count - w0 != 32) begin n_fail++; $display("FAIL full_writes got=%0d exp=32", wr_count - w0); end
        for (int i = 0; i < 32; i++) begin
            n_cmp++; if (mem[i] !== 16'h0000) begin n_fail++; $display("FAIL full_row%0d got=%h exp=0000", i, mem[i]); end
        end
    endtask

    task automatic test_reset_mid;
        bit hit;
        stall_len = 5;
        load_board(16'hFFFF, 16'h00F0, 16'hFFFF, 16'h8001, 1'b0);
        @(negedge clk) v_i = 1'b1;
        @(negedge clk) v_i = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (state_o == 3'd4 && mm_if.mm_is_ready == 1'b0) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_cmp++; if (hit !== 1'b1) begin n_fail++; $display("FAIL mid_reach_waitw got=%b exp=1", hit); end
        reset_i = 1'b1;
        #1;
        n_cmp++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", busy_o); end
        n_cmp++; if (mm_if.mm_wr_v !== 1'b0) begin n_fail++; $display("FAIL mid_wr_v got=%b exp=0", mm_if.mm_wr_v); end
        n_cmp++; if (lines_cleared_o !== 6'd0) begin n_fail++; $display("FAIL mid_lines got=%0d exp=0", lines_cleared_o); end
        @(negedge clk);
        @(negedge clk) reset_i = 1'b0;
        stall_len = 0;
        repeat (8) @(negedge clk);
        test_two_full(0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_empty();
        test_one_move();
        test_two_full(0, "two");
        test_all_full();
        test_two_full(5, "stall");
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
